tristate_bus_arbiter: RTL and testbench
=======================================

Name: tristate_bus_arbiter

Overview:
- Owns the direction control of a shared bidirectional tristate link between side A and side B.
- Arbitrates between the two drivers and grants the bus to one side at a time.
- Inserts dead (turnaround) cycles with both enables low whenever ownership changes, so the two sides never drive at once.
- Sits directly above the tristate pad/buffer block and drives its ctrl input.

Parameters:
TURN_CYCLES, 2, number of dead cycles with both enables low on an ownership change; legal range 1..15.
MAX_HOLD, 8, maximum consecutive granted cycles while the other side is requesting; legal range 1..15.
CNT_W, 4, width of the internal turn and hold counters; must hold max(TURN_CYCLES, MAX_HOLD).

Ports:
clk     input   1  single clock; all state updates on the rising edge
rst     input   1  synchronous, active-high reset
req_a   input   1  side A requests to drive the bus; level-sensitive, held until done
req_b   input   1  side B requests to drive the bus; level-sensitive
gnt_a   output  1  A owns the bus this cycle
gnt_b   output  1  B owns the bus this cycle
oe_a    output  1  A driver enable; equals gnt_a
oe_b    output  1  B driver enable; equals gnt_b
ctrl    output  1  direction to the tristate block: 1 = A drives toward B, 0 = B drives toward A; holds last owner
turn    output  1  high during turnaround cycles
busy    output  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset (sampled at a clk edge with rst=1):
  - state=IDLE; gnt_a, gnt_b, oe_a, oe_b, turn, busy all 0.
  - ctrl=0; last_owner=B; both counters 0.
  - Reset mid-grant or mid-turn: the enables are low from the first edge after rst is sampled high.
- States: IDLE, GNT_A, GNT_B, TURN. A `pending` register holds the owner targeted by TURN.
- IDLE:
  - Only the last owner requesting: grant that side next cycle. No turnaround; ctrl is unchanged.
  - Only the other side requesting: go to TURN with pending = that side.
  - Both requesting: prefer the side that is not last_owner (round-robin), so go to TURN.
  - Neither requesting: stay in IDLE.
- GNT_X:
  - Hold counter increments each cycle and saturates at MAX_HOLD. It clears on entry.
  - req_X low:
    - other side requesting: go to TURN with pending = other side.
    - otherwise: go to IDLE.
    - gnt_X drops on the edge after req_X is sampled low.
  - req_X high, other side requesting, and hold count == MAX_HOLD: forced release; go to TURN with pending = other side.
  - req_X high and other side idle: stay indefinitely.
- TURN:
  - gnt and oe are all 0; turn=1. Lasts exactly TURN_CYCLES cycles, counted with a down-counter.
  - On the last turn cycle:
    - req_pending high: go to GNT_pending. ctrl updates to the pending side on the same edge gnt rises. last_owner = pending.
    - req_pending low: go to IDLE. ctrl keeps its old value.
  - Requests arriving during TURN do not alter pending.
- Latency, with a request sampled at cycle N:
  - Same side as last owner from IDLE: gnt at N+1.
  - Ownership change: gnt at N+1+TURN_CYCLES.
  - Release with the other side waiting: gnt_X low at N+1, gnt_other high at N+1+TURN_CYCLES.
- Invariants that must never be violated:
  - gnt_a & gnt_b == 0 and oe_a & oe_b == 0.
  - At least TURN_CYCLES cycles with both oe low between oe_a falling and oe_b rising, and vice versa.
  - ctrl changes only on an edge where a gnt rises.
- busy = (state != IDLE).

Test Plan:
- Reset then req_a=1 only: gnt_a=0 through TURN (last_owner=B), turn high for 2 cycles, gnt_a=oe_a=ctrl=1 at cycle 3 after the request.
- A granted, drop req_a with req_b=0: gnt_a low the next cycle, busy=0, ctrl stays 1. Raise req_a again: gnt_a in 1 cycle, turn never high.
- A granted, req_b raised and held with req_a held: gnt_a stays high exactly MAX_HOLD=8 cycles after req_b is seen, then 2 turn cycles, then gnt_b=1, ctrl=0.
- req_a and req_b rise in the same cycle from IDLE after reset: B is last_owner, so A wins. After A releases, B is granted after 2 dead cycles.
- A releases to pending B, and req_b drops during TURN: state goes to IDLE after turn, gnt_b never asserted, ctrl stays 1.
- rst asserted while gnt_b=1 and while turn=1: every output equals its reset value on the next edge. Across all randomized runs, assert oe_a&oe_b==0 and a dead gap ≥ TURN_CYCLES on every direction change.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// Direction controller for a shared bidirectional tristate link between
// side A and side B. It grants the bus to one side at a time and inserts
// turnaround cycles, with both driver enables low, on every ownership change.
module tristate_bus_arbiter #(
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned MAX_HOLD    = 8,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic oe_a,
    output logic oe_b,
    output logic ctrl,
    output logic turn,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2,
        TURN  = 2'd3
    } state_t;

    // Side encoding matches ctrl: 1 = A drives, 0 = B drives.
    localparam logic SIDE_A = 1'b1;
    localparam logic SIDE_B = 1'b0;

    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    logic             last_owner;
    logic             pending;
    logic [CNT_W-1:0] turn_cnt;
    logic [CNT_W-1:0] hold_cnt;

    logic req_last_c;
    logic req_other_c;
    logic req_pend_c;

    // Requests viewed relative to the last owner and to the pending target.
    always_comb begin
        req_last_c  = (last_owner == SIDE_A) ? req_a : req_b;
        req_other_c = (last_owner == SIDE_A) ? req_b : req_a;
        req_pend_c  = (pending == SIDE_A) ? req_a : req_b;
    end

    // Arbitration state machine; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= SIDE_B;
            pending    <= SIDE_B;
            turn_cnt   <= '0;
            hold_cnt   <= '0;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            oe_a       <= 1'b0;
            oe_b       <= 1'b0;
            ctrl       <= 1'b0;
            turn       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            oe_a  <= 1'b0;
            oe_b  <= 1'b0;
            turn  <= 1'b0;
            busy  <= 1'b0;

            case (state)
                IDLE: begin
                    // Round-robin: the non-last-owner wins whenever it asks.
                    if (req_other_c) begin
                        state    <= TURN;
                        pending  <= ~last_owner;
                        turn_cnt <= TURN_LOAD;
                        turn     <= 1'b1;
                        busy     <= 1'b1;
                    end else if (req_last_c) begin
                        // Same side as before: no turnaround, ctrl already correct.
                        state    <= (last_owner == SIDE_A) ? GNT_A : GNT_B;
                        hold_cnt <= '0;
                        gnt_a    <= (last_owner == SIDE_A);
                        oe_a     <= (last_owner == SIDE_A);
                        gnt_b    <= (last_owner == SIDE_B);
                        oe_b     <= (last_owner == SIDE_B);
                        busy     <= 1'b1;
                    end
                end

                GNT_A: begin
                    if (!req_a || (req_b && (hold_cnt == HOLD_MAX))) begin
                        if (req_b) begin
                            state    <= TURN;
                            pending  <= SIDE_B;
                            turn_cnt <= TURN_LOAD;
                            turn     <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gnt_a <= 1'b1;
                        oe_a  <= 1'b1;
                        busy  <= 1'b1;
                        // Hold budget only runs while the other side is waiting.
                        if (!req_b) begin
                            hold_cnt <= '0;
                        end else if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + CNT_ONE;
                        end
                    end
                end

                GNT_B: begin
                    if (!req_b || (req_a && (hold_cnt == HOLD_MAX))) begin
                        if (req_a) begin
                            state    <= TURN;
                            pending  <= SIDE_A;
                            turn_cnt <= TURN_LOAD;
                            turn     <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gnt_b <= 1'b1;
                        oe_b  <= 1'b1;
                        busy  <= 1'b1;
                        if (!req_a) begin
                            hold_cnt <= '0;
                        end else if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + CNT_ONE;
                        end
                    end
                end

                TURN: begin
                    if (turn_cnt <= CNT_ONE) begin
                        turn_cnt <= '0;
                        // Last dead cycle: hand over only if the target still wants it.
                        if (req_pend_c) begin
                            state      <= (pending == SIDE_A) ? GNT_A : GNT_B;
                            hold_cnt   <= '0;
                            last_owner <= pending;
                            ctrl       <= pending;
                            gnt_a      <= (pending == SIDE_A);
                            oe_a       <= (pending == SIDE_A);
                            gnt_b      <= (pending == SIDE_B);
                            oe_b       <= (pending == SIDE_B);
                            busy       <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        turn_cnt <= turn_cnt - CNT_ONE;
                        turn     <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed and random-stimulus bench for tristate_bus_arbiter.
module tb_tristate_bus_arbiter;

    localparam int unsigned TURN_CYCLES = 2;
    localparam int unsigned MAX_HOLD    = 8;
    localparam int unsigned CNT_W       = 4;

    logic clk;
    logic rst;
    logic req_a;
    logic req_b;
    logic gnt_a;
    logic gnt_b;
    logic oe_a;
    logic oe_b;
    logic ctrl;
    logic turn;
    logic busy;

    // Observed vector: {gnt_a, gnt_b, oe_a, oe_b, ctrl, turn, busy}
    logic [6:0] obs;
    assign obs = {gnt_a, gnt_b, oe_a, oe_b, ctrl, turn, busy};

    int tests_run    = 0;
    int tests_failed = 0;
    bit mon_en       = 1'b0;

    tristate_bus_arbiter #(
        .TURN_CYCLES(TURN_CYCLES),
        .MAX_HOLD   (MAX_HOLD),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req_a(req_a),
        .req_b(req_b),
        .gnt_a(gnt_a),
        .gnt_b(gnt_b),
        .oe_a (oe_a),
        .oe_b (oe_b),
        .ctrl (ctrl),
        .turn (turn),
        .busy (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock: inputs set before this call are sampled at the posedge,
    // outputs are observed at the following negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Invariant monitor: mutual exclusion, dead gap on direction change,
    // and ctrl moving only together with a rising grant.
    logic prev_oe_a   = 1'b0;
    logic prev_oe_b   = 1'b0;
    logic prev_gnt_a  = 1'b0;
    logic prev_gnt_b  = 1'b0;
    logic prev_ctrl   = 1'b0;
    int   last_side   = 0;  // 0 none, 1 A, 2 B
    int   gap         = 0;

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            tests_run++;
            if (((oe_a & oe_b) !== 1'b0) || ((gnt_a & gnt_b) !== 1'b0)) begin
                tests_failed++;
                $display("FAIL mutex: oe_a=%b oe_b=%b gnt_a=%b gnt_b=%b, required no overlap",
                         oe_a, oe_b, gnt_a, gnt_b);
            end
            if ((oe_a === 1'b1) && (prev_oe_a === 1'b0) && (last_side == 2)) begin
                tests_run++;
                if (gap < int'(TURN_CYCLES)) begin
                    tests_failed++;
                    $display("FAIL gap_b_to_a: got %0d dead cycles, required >= %0d", gap, TURN_CYCLES);
                end
            end
            if ((oe_b === 1'b1) && (prev_oe_b === 1'b0) && (last_side == 1)) begin
                tests_run++;
                if (gap < int'(TURN_CYCLES)) begin
                    tests_failed++;
                    $display("FAIL gap_a_to_b: got %0d dead cycles, required >= %0d", gap, TURN_CYCLES);
                end
            end
            if (!rst && (ctrl !== prev_ctrl)) begin
                tests_run++;
                if (!((gnt_a && !prev_gnt_a) || (gnt_b && !prev_gnt_b))) begin
                    tests_failed++;
                    $display("FAIL ctrl_change: ctrl %b->%b without rising grant (gnt_a=%b gnt_b=%b)",
                             prev_ctrl, ctrl, gnt_a, gnt_b);
                end
            end
            if (oe_a === 1'b1) begin
                last_side = 1;
                gap = 0;
            end else if (oe_b === 1'b1) begin
                last_side = 2;
                gap = 0;
            end else begin
                gap++;
            end
            prev_oe_a  = oe_a;
            prev_oe_b  = oe_b;
            prev_gnt_a = gnt_a;
            prev_gnt_b = gnt_b;
            prev_ctrl  = ctrl;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        tick();
        tests_run++;
        if (obs !== 7'b0000000) begin
            tests_failed++;
            $display("FAIL reset_state: got %b required %b", obs, 7'b0000000);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        tick();
        tests_run++;
        if (obs !== 7'b0000000) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %b required %b", obs, 7'b0000000);
        end
    endtask

    task automatic test_first_grant();
        req_a = 1'b1;
        for (int i = 0; i < int'(TURN_CYCLES); i++) begin
            tick();
            tests_run++;
            if (obs !== 7'b0000011) begin
                tests_failed++;
                $display("FAIL first_grant_turn%0d: got %b required %b", i, obs, 7'b0000011);
            end
        end
        tick();
        tests_run++;
        if (obs !== 7'b1010101) begin
            tests_failed++;
            $display("FAIL first_grant_gnt_a: got %b required %b", obs, 7'b1010101);
        end
    endtask

    task automatic test_release_regrant();
        req_a = 1'b0;
        tick();
        tests_run++;
        if (obs !== 7'b0000100) begin
            tests_failed++;
            $display("FAIL release_idle: got %b required %b", obs, 7'b0000100);
        end
        req_a = 1'b1;
        tick();
        tests_run++;
        if (obs !== 7'b1010101) begin
            tests_failed++;
            $display("FAIL regrant_same_side: got %b required %b", obs, 7'b1010101);
        end
    endtask

    task automatic test_max_hold();
        req_b = 1'b1;
        for (int i = 0; i < int'(MAX_HOLD); i++) begin
            tick();
            tests_run++;
            if (obs !== 7'b1010101) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d: got %b required %b", i, obs, 7'b1010101);
            end
        end
        for (int i = 0; i < int'(TURN_CYCLES); i++) begin
            tick();
            tests_run++;
            if (obs !== 7'b0000111) begin
                tests_failed++;
                $display("FAIL forced_turn%0d: got %b required %b", i, obs, 7'b0000111);
            end
        end
        tick();
        tests_run++;
        if (obs !== 7'b0101001) begin
            tests_failed++;
            $display("FAIL forced_gnt_b: got %b required %b", obs, 7'b0101001);
        end
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        tests_run++;
        if (obs !== 7'b0000000) begin
            tests_failed++;
            $display("FAIL b_release: got %b required %b", obs, 7'b0000000);
        end
    endtask

    task automatic test_simultaneous();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_a = 1'b1;
        req_b = 1'b1;
        tick();
        tests_run++;
        if (obs !== 7'b0000011) begin
            tests_failed++;
            $display("FAIL simul_turn0: got %b required %b", obs, 7'b0000011);
        end
        tick();
        tick();
        tests_run++;
        if (obs !== 7'b1010101) begin
            tests_failed++;
            $display("FAIL simul_a_wins: got %b required %b", obs, 7'b1010101);
        end
        req_a = 1'b0;
        tick();
        tests_run++;
        if (obs !== 7'b0000111) begin
            tests_failed++;
            $display("FAIL simul_release_turn: got %b required %b", obs, 7'b0000111);
        end
        tick();
        tick();
        tests_run++;
        if (obs !== 7'b0101001) begin
            tests_failed++;
            $display("FAIL simul_b_granted: got %b required %b", obs, 7'b0101001);
        end
    endtask

    task automatic test_pending_drop();
        // Move ownership to A first.
        req_b = 1'b0;
        req_a = 1'b1;
        tick();
        tick();
        tick();
        tests_run++;
        if (obs !== 7'b1010101) begin
            tests_failed++;
            $display("FAIL drop_setup_a: got %b required %b", obs, 7'b1010101);
        end
        req_a = 1'b0;
        req_b = 1'b1;
        tick();
        tests_run++;
        if (obs !== 7'b0000111) begin
            tests_failed++;
            $display("FAIL drop_turn0: got %b required %b", obs, 7'b0000111);
        end
        req_b = 1'b0;
        tick();
        tests_run++;
        if (obs !== 7'b0000111) begin
            tests_failed++;
            $display("FAIL drop_turn1: got %b required %b", obs, 7'b0000111);
        end
        tick();
        tests_run++;
        if (obs !== 7'b0000100) begin
            tests_failed++;
            $display("FAIL drop_to_idle: got %b required %b", obs, 7'b0000100);
        end
        tick();
        tests_run++;
        if (obs !== 7'b0000100) begin
            tests_failed++;
            $display("FAIL drop_stays_idle: got %b required %b", obs, 7'b0000100);
        end
    endtask

    task automatic test_reset_mid();
        req_b = 1'b1;
        tick();
        tick();
        tick();
        tests_run++;
        if (obs !== 7'b0101001) begin
            tests_failed++;
            $display("FAIL mid_setup_b: got %b required %b", obs, 7'b0101001);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (obs !== 7'b0000000) begin
            tests_failed++;
            $display("FAIL reset_mid_grant: got %b required %b", obs, 7'b0000000);
        end
        rst = 1'b0;
        req_b = 1'b0;
        req_a = 1'b1;
        tick();
        tests_run++;
        if (obs !== 7'b0000011) begin
            tests_failed++;
            $display("FAIL mid_setup_turn: got %b required %b", obs, 7'b0000011);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (obs !== 7'b0000000) begin
            tests_failed++;
            $display("FAIL reset_mid_turn: got %b required %b", obs, 7'b0000000);
        end
        rst = 1'b0;
        req_a = 1'b0;
        tick();
        tests_run++;
        if (obs !== 7'b0000000) begin
            tests_failed++;
            $display("FAIL after_mid_reset: got %b required %b", obs, 7'b0000000);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) req_a = ~req_a;
            if ($urandom_range(0, 5) == 0) req_b = ~req_b;
            tick();
        end
        req_a = 1'b0;
        req_b = 1'b0;
        for (int i = 0; i < int'(TURN_CYCLES) + 2; i++) begin
            tick();
        end
        tests_run++;
        if ({gnt_a, gnt_b, oe_a, oe_b, turn, busy} !== 6'b000000) begin
            tests_failed++;
            $display("FAIL random_drain: got %b required %b",
                     {gnt_a, gnt_b, oe_a, oe_b, turn, busy}, 6'b000000);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_grant();
        test_release_regrant();
        test_max_hold();
        test_simultaneous();
        test_pending_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
